craft_round_ctrl: RTL and testbench
===================================

# craft_round_ctrl

Round sequencer for the CRAFT block-cipher core. Accepts one block request, drives the round datapath through all rounds with a one-cycle load strobe and per-round enables, and presents the matching 8-bit round constant and tweakey select each cycle. Contains its own forward/inverse constant generator; the round datapath and tweakey registers hang off its outputs. One block in flight at a time.

## Interface
- NUM_ROUNDS, 32, rounds per block; legal 2..32.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  block request.
- in_ready  out  1  high only in IDLE.
- decrypt  in  1  direction, sampled on acceptance; ignored unless CRAFT_DECRYPT_EN.
- abort  in  1  synchronous cancel.
- load_en  out  1  datapath loads input block.
- round_en  out  1  datapath executes one round.
- round_idx  out  5  current round number, 0..NUM_ROUNDS-1.
- last_round  out  1  round_en && round_idx==NUM_ROUNDS-1.
- rc  out  8  round constant {a[3:0],1'b0,b[2:0]}.
- tk_sel  out  2  tweakey index for this round.
- out_valid  out  1  result ready in datapath.
- out_ready  in  1  consumer takes result.
- busy  out  1  state != IDLE.

## Operation
- FSM IDLE -> LOAD -> RUN -> DONE -> IDLE.
- IDLE: in_ready=1. On in_valid && !abort: latch decrypt, go LOAD.
- LOAD: one cycle, load_en=1. Round counter cleared. Generator holds the start constant. Go RUN.
- RUN: round_en=1 for NUM_ROUNDS cycles. round_idx increments each cycle. Generator steps once per RUN cycle. After the round_idx==NUM_ROUNDS-1 cycle, go DONE.
- DONE: out_valid=1 until out_ready, then IDLE.
- abort in any state: IDLE at next edge, generator reinit to 0x11, counter 0. abort beats in_valid and out_ready.
- Generator forward step: a<={a[1]^a[0],a[3:1]}; b<={b[1]^b[0],b[2:1]}. Init a=4'h1, b=3'h1, so rc=0x11.
- Encryption sequence: RC_0=0x11, RC_1=0x84, RC_2=0x42, RC_3=0x25, RC_4=0x96; RC_31=0x85. Period: a 15, b 7.
- Encryption: rc=RC_round_idx; tk_sel=round_idx[1:0].
- Outputs are registered state decodes; rc comes directly from the generator registers.

## Timing
- Acceptance edge E0. load_en is high for E0..E1. round_en is high for E1..E(N+1). out_valid rises at E(N+1). Minimum latency N+1 cycles.
- out_valid, once high, stays high until an edge with out_ready=1 (or abort). The result is consumed on that edge.
- No back-to-back requests: in_valid during DONE is not accepted. Earliest next acceptance is one cycle after out_ready.
- Reset values: state IDLE, in_ready=1, busy=0, load_en=0, round_en=0, last_round=0, out_valid=0, round_idx=0, tk_sel=0, rc=0x11.
- Reset mid-block: immediate return to reset values; no partial out_valid.
- round_idx has no wrap. The counter holds at NUM_ROUNDS-1 leaving RUN and clears on entering LOAD or IDLE.

## Configuration
- CRAFT_DECRYPT_EN defined:
  - A decrypt=1 request loads the generator in LOAD with RC_(N-1) (0x85 for N=32).
  - The generator then steps with the inverse functions: a<={a[2:0],a[3]^a[0]}; b<={b[1:0],b[2]^b[0]}.
  - rc=RC_(N-1-round_idx) and tk_sel=(N-1-round_idx) mod 4.
- CRAFT_DECRYPT_EN undefined:
  - decrypt is ignored and the inverse-step logic is absent.
  - Every request runs the encryption sequence.

## Structure
- Package craft_pkg contains:
  - RC_INIT=8'h11 and the FSM state enum.
  - Functions rc_step, rc_step_inv and rc_at(n), a constant function used for the decrypt start value.
  - The NUM_ROUNDS legal range.
- Sub-module craft_rc_gen:
  - Ports: clk, rst_n, init (to 0x11), load + load_val, ce, dir.
  - Holds the a/b LFSR pair; the controller instantiates it once.

## Test plan
- Reset then idle: rc=0x11, in_ready=1, all strobes 0.
- Encrypt, N=32, out_ready=1:
  - load_en for 1 cycle, then round_en for 32 cycles.
  - rc sequence starts 0x11,0x84,0x42,0x25,0x96 and ends 0x85.
  - tk_sel cycles 0,1,2,3.
  - last_round is high only at idx 31.
  - out_valid rises 33 cycles after acceptance.
- out_ready held low 10 cycles: out_valid stays high, in_valid is ignored, acceptance resumes after the out_ready edge.
- abort at round 7: IDLE next cycle, rc=0x11. A new request then produces the full correct sequence.
- rst_n asserted mid-RUN: all outputs return to reset values immediately, without waiting for a clock edge.
- With CRAFT_DECRYPT_EN, decrypt=1:
  - rc runs 0x85 ... 0x25,0x42,0x84,0x11.
  - tk_sel starts at 3.
  - Without the macro, the same stimulus yields the encryption sequence.

Source files
------------

// File: rtl/craft_pkg.sv
// Shared types, constants and round-constant helpers for the CRAFT round sequencer.
// Constant layout is {a[3:0], 1'b0, b[2:0]}, with a/b two small LFSRs.
package craft_pkg;

    localparam logic [7:0] RC_INIT    = 8'h11;
    localparam int         ROUNDS_MIN = 2;
    localparam int         ROUNDS_MAX = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Forward step: a <= {a[1]^a[0], a[3:1]}, b <= {b[1]^b[0], b[2:1]}.
    function automatic logic [7:0] rc_step(input logic [7:0] v);
        return {v[5] ^ v[4], v[7:5], 1'b0, v[1] ^ v[0], v[2:1]};
    endfunction

    // Inverse step: a <= {a[2:0], a[3]^a[0]}, b <= {b[1:0], b[2]^b[0]}.
    function automatic logic [7:0] rc_step_inv(input logic [7:0] v);
        return {v[6:4], v[7] ^ v[4], 1'b0, v[1:0], v[2] ^ v[0]};
    endfunction

    // Constant for round n, evaluated at elaboration for the decrypt start value.
    function automatic logic [7:0] rc_at(input int n);
        logic [7:0] r;
        r = RC_INIT;
        for (int i = 0; i < n; i++) r = rc_step(r);
        return r;
    endfunction

endpackage

// File: rtl/craft_round_ctrl_if.sv
// Request / round-strobe / result bundle between the CRAFT sequencer and its user.
// Handshakes: a request transfers on an edge with in_valid && in_ready; a result transfers on an edge with out_valid && out_ready; abort overrides both.
interface craft_round_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic       decrypt;
    logic       abort;
    logic       load_en;
    logic       round_en;
    logic [4:0] round_idx;
    logic       last_round;
    logic [7:0] rc;
    logic [1:0] tk_sel;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    modport master (
        output in_valid, decrypt, abort, out_ready,
        input  in_ready, load_en, round_en, round_idx, last_round, rc, tk_sel, out_valid, busy
    );

    modport slave (
        input  in_valid, decrypt, abort, out_ready,
        output in_ready, load_en, round_en, round_idx, last_round, rc, tk_sel, out_valid, busy
    );
endinterface

// File: rtl/craft_rc_gen.sv
// Round-constant generator: the a/b LFSR pair with reinit, parallel load and step.
// CRAFT_DECRYPT_EN adds the inverse step selected by dir; otherwise dir is ignored.
module craft_rc_gen
    import craft_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       init,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       ce,
    input  logic       dir,
    output logic [7:0] rc
);

    logic [7:0] rc_q;
    logic [7:0] rc_next;

`ifdef CRAFT_DECRYPT_EN
    assign rc_next = dir ? rc_step_inv(rc_q) : rc_step(rc_q);
`else
    logic unused_dir;
    assign unused_dir = dir;
    assign rc_next    = rc_step(rc_q);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    rc_q <= RC_INIT;
        else if (init) rc_q <= RC_INIT;
        else if (load) rc_q <= load_val;
        else if (ce)   rc_q <= rc_next;
    end

    assign rc = rc_q;

endmodule

// File: rtl/craft_round_ctrl.sv
// CRAFT round sequencer: IDLE -> LOAD -> RUN (NUM_ROUNDS cycles) -> DONE, one block in flight.
// Optional feature macro: CRAFT_DECRYPT_EN (inverse constant schedule for decrypt requests).
module craft_round_ctrl
    import craft_pkg::*;
#(
    parameter int NUM_ROUNDS = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    craft_round_ctrl_if.slave   bus,
    output state_t              dbg_state
);

    // Out-of-range round counts are clamped into the supported window.
    localparam int N = (NUM_ROUNDS < ROUNDS_MIN) ? ROUNDS_MIN :
                       (NUM_ROUNDS > ROUNDS_MAX) ? ROUNDS_MAX : NUM_ROUNDS;
    localparam logic [4:0] LAST = 5'(N - 1);

    state_t     state_q, state_d;
    logic [4:0] idx_q;
    logic       dec_q;
    logic       accept;
    logic       gen_init;
    logic [7:0] load_val;
    logic [7:0] rc_w;

    assign accept   = (state_q == ST_IDLE) && bus.in_valid && !bus.abort;
    assign gen_init = bus.abort || ((state_q == ST_DONE) && bus.out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.in_valid)     state_d = ST_LOAD;
            ST_LOAD:                       state_d = ST_RUN;
            ST_RUN:  if (idx_q == LAST)    state_d = ST_DONE;
            ST_DONE: if (bus.out_ready)    state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
        if (bus.abort) state_d = ST_IDLE;
    end

    // The counter parks at LAST through DONE and is zero in IDLE and LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   idx_q <= '0;
        else if (bus.abort)           idx_q <= '0;
        else if (state_q == ST_RUN) begin
            if (idx_q != LAST)        idx_q <= idx_q + 5'd1;
        end
        else if (state_q == ST_DONE) begin
            if (bus.out_ready)        idx_q <= '0;
        end
        else                          idx_q <= '0;
    end

`ifdef CRAFT_DECRYPT_EN
    localparam logic [7:0] RC_DEC_START = rc_at(N - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      dec_q <= 1'b0;
        else if (accept) dec_q <= bus.decrypt;
    end

    assign load_val   = bus.decrypt ? RC_DEC_START : RC_INIT;
    assign bus.tk_sel = dec_q ? (LAST[1:0] - idx_q[1:0]) : idx_q[1:0];
`else
    logic unused_decrypt;
    assign unused_decrypt = bus.decrypt;
    assign dec_q          = 1'b0;
    assign load_val       = RC_INIT;
    assign bus.tk_sel     = idx_q[1:0];
`endif

    craft_rc_gen u_rc_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .init     (gen_init),
        .load     (accept),
        .load_val (load_val),
        .ce       (state_q == ST_RUN),
        .dir      (dec_q),
        .rc       (rc_w)
    );

    assign bus.in_ready   = (state_q == ST_IDLE);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.load_en    = (state_q == ST_LOAD);
    assign bus.round_en   = (state_q == ST_RUN);
    assign bus.out_valid  = (state_q == ST_DONE);
    assign bus.round_idx  = idx_q;
    assign bus.last_round = (state_q == ST_RUN) && (idx_q == LAST);
    assign bus.rc         = rc_w;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_craft_round_ctrl.sv
// Self-checking bench for craft_round_ctrl: randomized blocks against a constant-schedule model.
// Observed outputs are packed {load_en, round_en, round_idx, last_round, rc, tk_sel, out_valid, in_ready, busy}.
module tb_craft_round_ctrl;
    import craft_pkg::*;

    localparam int N = 32;
    localparam int W = 21;
`ifdef CRAFT_DECRYPT_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    state_t dbg_state;

    craft_round_ctrl_if bus();

    craft_round_ctrl #(.NUM_ROUNDS(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] enc_rc [128];
    logic [7:0] lit_rc [6];
    logic [W-1:0] exp_q [$];

    // Constant schedule from the LFSR rules, computed on plain integers.
    task automatic build_model();
        int a, b;
        a = 1; b = 1;
        for (int i = 0; i < 128; i++) begin
            enc_rc[i] = 8'((a << 4) | b);
            a = (a >> 1) | (((a ^ (a >> 1)) & 1) << 3);
            b = (b >> 1) | (((b ^ (b >> 1)) & 1) << 2);
        end
        lit_rc[0] = 8'h11; lit_rc[1] = 8'h84; lit_rc[2] = 8'h42;
        lit_rc[3] = 8'h25; lit_rc[4] = 8'h96; lit_rc[5] = 8'h85;
    endtask

    function automatic logic [W-1:0] ev(input logic le, input logic re, input int idx,
                                        input logic last, input logic [7:0] rc, input int tk,
                                        input logic ov, input logic ir, input logic bz);
        logic [4:0] i5;
        logic [1:0] t2;
        i5 = 5'(idx);
        t2 = 2'(tk);
        return {le, re, i5, last, rc, t2, ov, ir, bz};
    endfunction

    function automatic logic [W-1:0] observe();
        return {bus.load_en, bus.round_en, bus.round_idx, bus.last_round, bus.rc,
                bus.tk_sel, bus.out_valid, bus.in_ready, bus.busy};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete block from an IDLE sample point; ends at the next IDLE sample point.
    task automatic run_block(input string tag, input bit dec, input int stall);
        bit           edec;
        int           j;
        logic [W-1:0] obs, exp;
        edec = dec && DEC_EN;
        exp_q.delete();
        exp_q.push_back(ev(1, 0, 0, 0, edec ? enc_rc[N-1] : enc_rc[0], edec ? (N-1) % 4 : 0, 0, 0, 1));
        for (int k = 0; k < N; k++)
            exp_q.push_back(ev(0, 1, k, k == N-1, edec ? enc_rc[N-1-k] : enc_rc[k],
                               edec ? (N-1-k) % 4 : k % 4, 0, 0, 1));
        for (int s = 0; s <= stall; s++)
            exp_q.push_back(ev(0, 0, N-1, 0, edec ? enc_rc[104] : enc_rc[N], edec ? 0 : (N-1) % 4, 1, 0, 1));
        exp_q.push_back(ev(0, 0, 0, 0, 8'h11, 0, 0, 1, 0));

        bus.in_valid = 1'b1; bus.decrypt = dec; bus.out_ready = 1'b0;
        step();
        bus.in_valid = 1'b0;
        bus.decrypt  = 1'($urandom_range(0, 1));
        obs = observe(); exp = exp_q.pop_front(); n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s load: got %h want %h", tag, obs, exp);
        end
        step();
        for (int k = 0; k < N; k++) begin
            obs = observe(); exp = exp_q.pop_front(); n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL %s round %0d: got %h want %h", tag, k, obs, exp);
            end
            j = edec ? N-1-k : k;
            if (j < 5 || j == N-1) begin
                n_cmp++;
                if (bus.rc !== lit_rc[j < 5 ? j : 5]) begin
                    n_err++;
                    $display("FAIL %s rc_table round %0d: got %h want %h", tag, k, bus.rc, lit_rc[j < 5 ? j : 5]);
                end
            end
            step();
        end
        for (int s = 0; s <= stall; s++) begin
            obs = observe(); exp = exp_q.pop_front(); n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL %s done cyc %0d: got %h want %h", tag, s, obs, exp);
            end
            if (s == stall) begin
                bus.out_ready = 1'b1;
                bus.in_valid  = 1'b1;
            end else begin
                bus.out_ready = 1'b0;
                bus.in_valid  = 1'($urandom_range(0, 1));
            end
            step();
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        obs = observe(); exp = exp_q.pop_front(); n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s idle_after: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic test_reset();
        logic [W-1:0] obs;
        bus.in_valid = 1'b0; bus.decrypt = 1'b0; bus.abort = 1'b0; bus.out_ready = 1'b0;
        rst_n = 1'b0;
        #12;
        obs = observe(); n_cmp++;
        if (obs !== ev(0, 0, 0, 0, 8'h11, 0, 0, 1, 0)) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want %h", obs, ev(0, 0, 0, 0, 8'h11, 0, 0, 1, 0));
        end
        n_cmp++;
        if (dbg_state !== ST_IDLE) begin
            n_err++;
            $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE);
        end
        step();
        rst_n = 1'b1;
        step(); step();
        obs = observe(); n_cmp++;
        if (obs !== ev(0, 0, 0, 0, 8'h11, 0, 0, 1, 0)) begin
            n_err++;
            $display("FAIL idle_hold: got %h want %h", obs, ev(0, 0, 0, 0, 8'h11, 0, 0, 1, 0));
        end
    endtask

    task automatic test_encrypt();
        run_block("encrypt", 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        run_block("stall10", 1'b0, 10);
        run_block("after_stall", 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    endtask

    task automatic test_abort();
        logic [W-1:0] obs;
        bus.in_valid = 1'b1; bus.decrypt = 1'b0;
        step();
        bus.in_valid = 1'b0;
        step();
        for (int k = 0; k < 7; k++) step();
        n_cmp++;
        if (bus.round_idx !== 5'd7 || bus.rc !== enc_rc[7]) begin
            n_err++;
            $display("FAIL abort_pre idx/rc: got %0d/%h want 7/%h", bus.round_idx, bus.rc, enc_rc[7]);
        end
        bus.abort = 1'b1; bus.in_valid = 1'b1;
        step();
        bus.abort = 1'b0; bus.in_valid = 1'b0;
        obs = observe(); n_cmp++;
        if (obs !== ev(0, 0, 0, 0, 8'h11, 0, 0, 1, 0)) begin
            n_err++;
            $display("FAIL abort_idle: got %h want %h", obs, ev(0, 0, 0, 0, 8'h11, 0, 0, 1, 0));
        end
        run_block("post_abort", 1'b0, int'($urandom_range(0, 3)));
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] obs;
        bus.in_valid = 1'b1; bus.decrypt = 1'($urandom_range(0, 1));
        step();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 11; k++) step();
        #2;
        rst_n = 1'b0;
        #1;
        obs = observe(); n_cmp++;
        if (obs !== ev(0, 0, 0, 0, 8'h11, 0, 0, 1, 0)) begin
            n_err++;
            $display("FAIL reset_mid_run: got %h want %h", obs, ev(0, 0, 0, 0, 8'h11, 0, 0, 1, 0));
        end
        n_cmp++;
        if (dbg_state !== ST_IDLE) begin
            n_err++;
            $display("FAIL reset_mid_state: got %0d want %0d", dbg_state, ST_IDLE);
        end
        step();
        rst_n = 1'b1;
        step();
        run_block("post_reset", 1'b1, 2);
    endtask

    task automatic test_decrypt();
        run_block("decrypt", 1'b1, int'($urandom_range(0, 5)));
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++)
            run_block("random", 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
    endtask

    initial begin
        build_model();
        test_reset();
        test_encrypt();
        test_back_to_back();
        test_abort();
        test_reset_mid_run();
        test_decrypt();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
